product0_lv_deserializer: RTL and testbench

//  Receive end of the product0 packed link. Upstream sends each 18-bit

---
 rtl/product0_lv_deserializer.sv | 95 +++++++++
 tb/tb_product0_lv_deserializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/product0_lv_deserializer.sv
// rtl/product0_lv_deserializer.sv - reassembles two 9-bit beats into one product0 word
// Holds the hi beat separately so it can be taken while the output register is stalled.
module product0_lv_deserializer #(
    parameter int DATA_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic                  system1000,
    input  logic                  system1000_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_sop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_sel0,
    output logic [DATA_W-1:0]     out_sel1,
    output logic [2*DATA_W-1:0]   out_lv,
    output logic                  frame_err,
    output logic [CNT_W-1:0]      pair_cnt,
    output logic [CNT_W-1:0]      err_cnt
);

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_hi_q;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_sel0;
    logic [DATA_W-1:0]   r_sel1;
    logic                r_frame_err;
    logic [CNT_W-1:0]    r_pair_cnt;
    logic [CNT_W-1:0]    r_err_cnt;

    logic                w_ready;
    logic                w_accept;
    logic                w_load;

    // Only the lo beat needs room in the output register.
    assign w_ready  = (r_state == WAIT_HI) || !r_out_valid || out_ready;
    assign w_accept = in_valid && w_ready;
    assign w_load   = w_accept && (r_state == WAIT_LO) && !in_sop;

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_state     <= WAIT_HI;
            r_hi_q      <= '0;
            r_out_valid <= 1'b0;
            r_sel0      <= '0;
            r_sel1      <= '0;
            r_frame_err <= 1'b0;
            r_pair_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_frame_err <= 1'b0;

            if (w_load) begin
                r_sel0      <= r_hi_q;
                r_sel1      <= in_data;
                r_out_valid <= 1'b1;
                r_pair_cnt  <= r_pair_cnt + CNT_W'(1);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                if (r_state == WAIT_HI) begin
                    r_hi_q  <= in_data;
                    r_state <= WAIT_LO;
                end else if (in_sop) begin
                    // A new sop while waiting for lo restarts the pair with this beat.
                    r_hi_q      <= in_data;
                    r_frame_err <= 1'b1;
                    if (r_err_cnt != {CNT_W{1'b1}}) begin
                        r_err_cnt <= r_err_cnt + CNT_W'(1);
                    end
                end else begin
                    r_state <= WAIT_HI;
                end
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_sel0  = r_sel0;
    assign out_sel1  = r_sel1;
    assign out_lv    = {r_sel0, r_sel1};
    assign frame_err = r_frame_err;
    assign pair_cnt  = r_pair_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_product0_lv_deserializer.sv
// tb/tb_product0_lv_deserializer.sv - self-checking bench for product0_lv_deserializer
module tb_product0_lv_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_sop, out_ready;
    logic [8:0]  in_data;
    logic        in_ready, out_valid, frame_err;
    logic [8:0]  out_sel0, out_sel1;
    logic [17:0] out_lv;
    logic [15:0] pair_cnt, err_cnt;

    logic        n_in_valid, n_in_sop, n_out_ready;
    logic [8:0]  n_in_data;
    logic        n_in_ready, n_out_valid, n_frame_err;
    logic [8:0]  n_out_sel0, n_out_sel1;
    logic [17:0] n_out_lv;
    logic [3:0]  n_pair_cnt, n_err_cnt;

    always #5 clk = ~clk;

    product0_lv_deserializer dut (
        .system1000(clk), .system1000_rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sop(in_sop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sel0(out_sel0), .out_sel1(out_sel1), .out_lv(out_lv),
        .frame_err(frame_err), .pair_cnt(pair_cnt), .err_cnt(err_cnt)
    );

    product0_lv_deserializer #(.DATA_W(9), .CNT_W(4)) dut_n (
        .system1000(clk), .system1000_rst(rst),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_sop(n_in_sop),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_sel0(n_out_sel0), .out_sel1(n_out_sel1), .out_lv(n_out_lv),
        .frame_err(n_frame_err), .pair_cnt(n_pair_cnt), .err_cnt(n_err_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: a held hi beat (if any) and the one-deep output slot.
    bit          m_has_hi;
    logic [8:0]  m_hi;
    bit          m_valid;
    logic [17:0] m_lv;
    bit          m_ferr;
    int          m_pc;
    int          m_ec;
    bit          exp_ready;

    typedef struct {
        bit          v;
        logic [8:0]  d;
        bit          s;
        bit          r;
        bit          e_ready;
        bit          e_valid;
        logic [17:0] e_lv;
        bit          e_ferr;
        int          e_pc;
        int          e_ec;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_has_hi = 0; m_hi = '0; m_valid = 0; m_lv = '0; m_ferr = 0; m_pc = 0; m_ec = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_lv", 32'(out_lv), 32'(m_lv));
        chk("out_sel0", 32'(out_sel0), 32'(m_lv[17:9]));
        chk("out_sel1", 32'(out_sel1), 32'(m_lv[8:0]));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("pair_cnt", 32'(pair_cnt), 32'(m_pc % 65536));
        chk("err_cnt", 32'(err_cnt), 32'(m_ec));
    endtask

    // One clock: drive at negedge, check ready, advance model, check after the edge.
    task automatic cycle(input bit v, input logic [8:0] d, input bit s, input bit r);
        bit acc;
        in_valid = v; in_data = d; in_sop = s; out_ready = r;
        #1;
        exp_ready = !m_has_hi || !m_valid || r;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        m_ferr = 0;
        if (m_valid && r) m_valid = 0;
        if (acc) begin
            if (!m_has_hi) begin
                m_hi = d; m_has_hi = 1;
            end else if (s) begin
                m_hi = d; m_ferr = 1;
                if (m_ec < 65535) m_ec++;
            end else begin
                m_lv = {m_hi, d}; m_valid = 1; m_pc++; m_has_hi = 0;
            end
        end
        @(posedge clk); #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; in_data = '0; in_sop = 0; out_ready = 0;
        n_in_valid = 0; n_in_data = '0; n_in_sop = 0; n_out_ready = 1;
        @(posedge clk); #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic n_beat(input logic [8:0] d, input bit s);
        n_in_valid = 1; n_in_data = d; n_in_sop = s;
        @(posedge clk); #1;
        @(negedge clk);
        n_in_valid = 0;
    endtask

    vec_t vecs[13];

    initial begin
        int pc0;
        vecs[0]  = '{1, 9'h1FF, 1, 1, 1, 0, 18'h00000, 0, 0, 0};
        vecs[1]  = '{1, 9'h001, 0, 1, 1, 1, 18'h3FE01, 0, 1, 0};
        vecs[2]  = '{1, 9'h011, 1, 1, 1, 0, 18'h3FE01, 0, 1, 0};
        vecs[3]  = '{1, 9'h022, 1, 1, 1, 0, 18'h3FE01, 1, 1, 1};
        vecs[4]  = '{1, 9'h033, 0, 1, 1, 1, 18'h04433, 0, 2, 1};
        vecs[5]  = '{0, 9'h000, 0, 1, 1, 0, 18'h04433, 0, 2, 1};
        vecs[6]  = '{1, 9'h0AA, 1, 0, 1, 0, 18'h04433, 0, 2, 1};
        vecs[7]  = '{1, 9'h055, 0, 0, 1, 1, 18'h15455, 0, 3, 1};
        vecs[8]  = '{1, 9'h100, 1, 0, 1, 1, 18'h15455, 0, 3, 1};
        vecs[9]  = '{1, 9'h0CC, 0, 0, 0, 1, 18'h15455, 0, 3, 1};
        vecs[10] = '{1, 9'h0CC, 0, 0, 0, 1, 18'h15455, 0, 3, 1};
        vecs[11] = '{1, 9'h0CC, 0, 1, 1, 1, 18'h200CC, 0, 4, 1};
        vecs[12] = '{0, 9'h000, 0, 1, 1, 0, 18'h200CC, 0, 4, 1};

        @(negedge clk);
        do_reset();
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // T1/T3/T2 from a fixed table of hand-derived expectations.
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].r);
            chk($sformatf("vec%0d_ready", i), 32'(exp_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_lv", i), 32'(out_lv), 32'(vecs[i].e_lv));
            chk($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vecs[i].e_ferr));
            chk($sformatf("vec%0d_pc", i), 32'(pair_cnt), 32'(vecs[i].e_pc));
            chk($sformatf("vec%0d_ec", i), 32'(err_cnt), 32'(vecs[i].e_ec));
        end

        // T4: 8 back-to-back pairs, one output every second cycle.
        pc0 = 32'(pair_cnt);
        for (int p = 0; p < 8; p++) begin
            cycle(1, 9'(p * 3 + 1), 1, 1);
            chk("t4_gap_valid", 32'(out_valid), 32'd0);
            cycle(1, 9'(p * 5 + 2), 0, 1);
            chk("t4_lv", 32'(out_lv), 32'({9'(p * 3 + 1), 9'(p * 5 + 2)}));
        end
        chk("t4_pair_cnt", 32'(pair_cnt), 32'(pc0 + 8));

        // T5: reset with a hi beat held, then a clean pair.
        cycle(1, 9'h0AB, 1, 1);
        do_reset();
        chk("t5_zero_lv", 32'(out_lv), 32'd0);
        cycle(1, 9'h012, 0, 1);
        cycle(1, 9'h034, 0, 1);
        chk("t5_lv", 32'(out_lv), 32'h02434);
        chk("t5_pair_cnt", 32'(pair_cnt), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) != 0), 9'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        // T6: counter wrap and saturation on a 4-bit-counter instance.
        for (int p = 0; p < 17; p++) begin
            n_beat(9'(p), 1);
            n_beat(9'(p + 100), 0);
            if (p == 14) chk("n_pair_cnt_15", 32'(n_pair_cnt), 32'd15);
            if (p == 15) chk("n_pair_cnt_wrap", 32'(n_pair_cnt), 32'd0);
        end
        chk("n_pair_cnt_17", 32'(n_pair_cnt), 32'd1);
        chk("n_lv_last", 32'(n_out_lv), 32'({9'd16, 9'd116}));
        n_beat(9'h001, 1);
        for (int e = 0; e < 20; e++) begin
            n_beat(9'(e), 1);
            if (e == 14) chk("n_err_cnt_15", 32'(n_err_cnt), 32'd15);
        end
        chk("n_err_cnt_sat", 32'(n_err_cnt), 32'd15);
        chk("n_pair_cnt_after_err", 32'(n_pair_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
